// File: rtl/app_data_arbiter_pkg.sv
// Shared types and helpers for the app_data/conf buffer arbiter.
// Build option: define ARB_TIMEOUT_EN to enable forced revoke of long-held grants.
package app_data_arb_pkg;

  typedef enum logic {
    ARB_IDLE    = 1'b0,
    ARB_GRANTED = 1'b1
  } arb_state_t;

  localparam int ARB_FIXED = 0;
  localparam int ARB_RR    = 1;

  // Index of the lowest set bit of a one-hot vector (up to 16 requesters).
  function automatic logic [3:0] onehot_to_idx(input logic [15:0] onehot);
    logic [3:0] idx;
    idx = '0;
    for (int i = 15; i >= 0; i--) begin
      if (onehot[i]) idx = 4'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/app_data_arbiter_if.sv
// Requester-facing bundle of the app_data arbiter: request/release in, grant status out.
// Build option ARB_TIMEOUT_EN only changes how the timeout line is driven.
interface app_data_arbiter_if #(
  parameter int N_REQ = 2
);
  localparam int IDX_W = $clog2(N_REQ);

  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] rel;
  logic [N_REQ-1:0] grant;
  logic [IDX_W-1:0] owner;
  logic             busy;
  logic [N_REQ-1:0] pending;
  logic             timeout;

  modport master (
    output req, rel,
    input  grant, owner, busy, pending, timeout
  );

  modport slave (
    input  req, rel,
    output grant, owner, busy, pending, timeout
  );

endinterface

// File: rtl/app_data_arbiter_pick.sv
// Combinational winner selection: rotate candidates to the search start, find first set, unrotate.
// Independent of ARB_TIMEOUT_EN.
module arb_pick #(
  parameter int N_REQ = 2,
  localparam int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] candidates,
  input  logic [IDX_W-1:0] start,
  input  logic             rr_mode,
  output logic [IDX_W-1:0] winner,
  output logic             valid
);

  logic [IDX_W-1:0]   base;
  logic [IDX_W-1:0]   offset;
  logic [2*N_REQ-1:0] doubled;
  logic [N_REQ-1:0]   rotated;
  logic [IDX_W:0]     sum;

  always_comb begin
    base    = rr_mode ? start : '0;
    doubled = {candidates, candidates};
    rotated = doubled[base +: N_REQ];
    offset  = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (rotated[i]) offset = IDX_W'(i);
    end
    // Undo the rotation modulo N_REQ, which need not be a power of two.
    sum = {1'b0, base} + {1'b0, offset};
    if (sum >= (IDX_W+1)'(N_REQ)) begin
      winner = IDX_W'(sum - (IDX_W+1)'(N_REQ));
    end else begin
      winner = sum[IDX_W-1:0];
    end
    valid = |candidates;
  end

endmodule

// File: rtl/app_data_arbiter.sv
// N-requester owner arbiter for the shared ROS2 app_data/conf buffer (fixed or round-robin).
// Build option: define ARB_TIMEOUT_EN to revoke grants held for TIMEOUT_CYCLES cycles.
module app_data_arbiter
  import app_data_arb_pkg::*;
#(
  parameter int N_REQ          = 2,
  parameter int RR_MODE        = ARB_FIXED,
  parameter int TIMEOUT_CYCLES = 65536
) (
  input  logic               clk_int,
  input  logic               rst_int,
  app_data_arbiter_if.slave  bus
);

  localparam int IDX_W = $clog2(N_REQ);

  arb_state_t       state;
  logic [N_REQ-1:0] grant_q;
  logic [N_REQ-1:0] pending_q;
  logic [IDX_W-1:0] owner_q;
  logic [IDX_W-1:0] rr_ptr;

  logic [N_REQ-1:0] candidates;
  logic [N_REQ-1:0] winner_oh;
  logic [IDX_W-1:0] winner;
  logic [IDX_W-1:0] next_ptr;
  logic             win_valid;
  logic             rel_owner;
  logic             hold_expired;

`ifdef ARB_TIMEOUT_EN
  logic [31:0] hold_cnt;
  logic        timeout_q;

  assign hold_expired = (hold_cnt == 32'(TIMEOUT_CYCLES - 1));
  assign bus.timeout  = timeout_q;
`else
  assign hold_expired = 1'b0;
  assign bus.timeout  = 1'b0;
`endif

  assign candidates = pending_q | bus.req;
  assign winner_oh  = {{(N_REQ-1){1'b0}}, 1'b1} << winner;
  assign next_ptr   = (winner == IDX_W'(N_REQ - 1)) ? '0 : winner + 1'b1;
  // grant_q is one-hot on the owner, so this only sees rel[owner].
  assign rel_owner  = |(bus.rel & grant_q);

  arb_pick #(
    .N_REQ (N_REQ)
  ) u_pick (
    .candidates (candidates),
    .start      (rr_ptr),
    .rr_mode    (RR_MODE == ARB_RR),
    .winner     (winner),
    .valid      (win_valid)
  );

  always_ff @(posedge clk_int) begin
    if (rst_int) begin
      state     <= ARB_IDLE;
      grant_q   <= '0;
      pending_q <= '0;
      owner_q   <= '0;
      rr_ptr    <= '0;
`ifdef ARB_TIMEOUT_EN
      hold_cnt  <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
`ifdef ARB_TIMEOUT_EN
      timeout_q <= 1'b0;
`endif
      case (state)
        ARB_IDLE: begin
          if (win_valid) begin
            state     <= ARB_GRANTED;
            grant_q   <= winner_oh;
            owner_q   <= winner;
            rr_ptr    <= next_ptr;
            pending_q <= candidates & ~winner_oh;
`ifdef ARB_TIMEOUT_EN
            hold_cnt  <= '0;
`endif
          end else begin
            pending_q <= candidates;
          end
        end
        ARB_GRANTED: begin
          // A release also latches the owner's own coincident request.
          if (rel_owner) begin
            state     <= ARB_IDLE;
            grant_q   <= '0;
            pending_q <= pending_q | bus.req;
          end else if (hold_expired) begin
            state     <= ARB_IDLE;
            grant_q   <= '0;
            pending_q <= pending_q | (bus.req & ~grant_q);
`ifdef ARB_TIMEOUT_EN
            timeout_q <= 1'b1;
`endif
          end else begin
            pending_q <= pending_q | (bus.req & ~grant_q);
`ifdef ARB_TIMEOUT_EN
            hold_cnt  <= hold_cnt + 32'd1;
`endif
          end
        end
        default: begin
          state   <= ARB_IDLE;
          grant_q <= '0;
        end
      endcase
    end
  end

  assign bus.grant   = grant_q;
  assign bus.owner   = owner_q;
  assign bus.busy    = |grant_q;
  assign bus.pending = pending_q;

endmodule

// File: tb/tb_app_data_arbiter.sv
// Scoreboard bench: fixed and round-robin arbiters driven in parallel against a queue-based reference.
// With ARB_TIMEOUT_EN defined the reference also models forced revoke after 16 held cycles.
module tb_app_data_arbiter;

  localparam int NR = 4;
  localparam int TO = 16;
`ifdef ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  typedef struct {
    logic [3:0] grant;
    logic [1:0] owner;
    logic       busy;
    logic [3:0] pending;
    logic       timeout;
  } exp_t;

  logic clk;
  logic rst;

  int checks = 0;
  int errors = 0;

  exp_t q_exp[2][$];

  // Reference state per DUT: index 0 fixed priority, index 1 round-robin.
  bit         m_granted[2];
  int         m_owner[2];
  int         m_next[2];
  int         m_hold[2];
  logic [3:0] m_pending[2];
  bit         m_timeout[2];

  app_data_arbiter_if #(.N_REQ(NR)) bus_f ();
  app_data_arbiter_if #(.N_REQ(NR)) bus_r ();

  app_data_arbiter #(
    .N_REQ          (NR),
    .RR_MODE        (0),
    .TIMEOUT_CYCLES (TO)
  ) u_fix (
    .clk_int (clk),
    .rst_int (rst),
    .bus     (bus_f)
  );

  app_data_arbiter #(
    .N_REQ          (NR),
    .RR_MODE        (1),
    .TIMEOUT_CYCLES (TO)
  ) u_rr (
    .clk_int (clk),
    .rst_int (rst),
    .bus     (bus_r)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_step(input int d, input bit r, input logic [3:0] rq, input logic [3:0] rl);
    logic [3:0] cand;
    int start;
    int win;
    m_timeout[d] = 1'b0;
    if (r) begin
      m_granted[d] = 1'b0;
      m_owner[d]   = 0;
      m_next[d]    = 0;
      m_hold[d]    = 0;
      m_pending[d] = 4'b0;
    end else if (!m_granted[d]) begin
      cand = m_pending[d] | rq;
      if (cand != 4'b0) begin
        start = (d == 1) ? m_next[d] : 0;
        win = -1;
        for (int k = 0; k < NR; k++) begin
          if (win < 0 && cand[(start + k) % NR]) win = (start + k) % NR;
        end
        m_granted[d] = 1'b1;
        m_owner[d]   = win;
        m_next[d]    = (win + 1) % NR;
        m_hold[d]    = 0;
        cand[win]    = 1'b0;
      end
      m_pending[d] = cand;
    end else if (rl[m_owner[d]]) begin
      m_granted[d] = 1'b0;
      m_pending[d] = m_pending[d] | rq;
    end else begin
      rq[m_owner[d]] = 1'b0;
      m_pending[d] = m_pending[d] | rq;
      if (TO_EN && m_hold[d] == TO - 1) begin
        m_granted[d] = 1'b0;
        m_timeout[d] = 1'b1;
      end else begin
        m_hold[d] = m_hold[d] + 1;
      end
    end
  endtask

  function automatic exp_t model_view(input int d);
    exp_t e;
    e.grant   = m_granted[d] ? 4'(1 << m_owner[d]) : 4'b0;
    e.owner   = 2'(m_owner[d]);
    e.busy    = m_granted[d];
    e.pending = m_pending[d];
    e.timeout = m_timeout[d];
    return e;
  endfunction

  // Drive one cycle of inputs, predict the post-edge outputs, then advance past the edge.
  task automatic applyStimulus(input bit r, input logic [3:0] rq, input logic [3:0] rl);
    rst       = r;
    bus_f.req = rq;
    bus_f.rel = rl;
    bus_r.req = rq;
    bus_r.rel = rl;
    for (int d = 0; d < 2; d++) begin
      model_step(d, r, rq, rl);
      q_exp[d].push_back(model_view(d));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [3:0] act, input logic [3:0] req_v);
    checks++;
    if (act !== req_v) begin
      errors++;
      $display("[TB] FAIL %s actual=%h required=%h at %0t", name, act, req_v, $time);
    end
  endtask

  // Monitor: every negedge the DUTs present a full status word; compare against the oldest prediction.
  always @(negedge clk) begin
    exp_t e;
    if (q_exp[0].size() > 0) begin
      e = q_exp[0].pop_front();
      checkOutput("fix.grant",   bus_f.grant,            e.grant);
      checkOutput("fix.owner",   {2'b0, bus_f.owner},    {2'b0, e.owner});
      checkOutput("fix.busy",    {3'b0, bus_f.busy},     {3'b0, e.busy});
      checkOutput("fix.pending", bus_f.pending,          e.pending);
      checkOutput("fix.timeout", {3'b0, bus_f.timeout},  {3'b0, e.timeout});
    end
    if (q_exp[1].size() > 0) begin
      e = q_exp[1].pop_front();
      checkOutput("rr.grant",    bus_r.grant,            e.grant);
      checkOutput("rr.owner",    {2'b0, bus_r.owner},    {2'b0, e.owner});
      checkOutput("rr.busy",     {3'b0, bus_r.busy},     {3'b0, e.busy});
      checkOutput("rr.pending",  bus_r.pending,          e.pending);
      checkOutput("rr.timeout",  {3'b0, bus_r.timeout},  {3'b0, e.timeout});
    end
  end

  initial begin
    logic [3:0] rq;
    logic [3:0] rl;
    int d;
    int sel;

    // Reset
    applyStimulus(1'b1, 4'b0000, 4'b0000);
    applyStimulus(1'b1, 4'b0000, 4'b0000);
    applyStimulus(1'b0, 4'b0000, 4'b0000);

    // Two simultaneous pulses, owner 0 releases a few cycles later, then 1 takes over
    applyStimulus(1'b0, 4'b0011, 4'b0000);
    repeat (4) applyStimulus(1'b0, 4'b0000, 4'b0000);
    applyStimulus(1'b0, 4'b0000, 4'b0001);
    repeat (3) applyStimulus(1'b0, 4'b0000, 4'b0000);
    applyStimulus(1'b0, 4'b0000, 4'b0010);
    applyStimulus(1'b0, 4'b0000, 4'b0000);

    // All requesters held; the round-robin owner releases on its second granted cycle
    for (int c = 0; c < 24; c++) begin
      rl = (m_granted[1] && m_hold[1] == 1) ? 4'(1 << m_owner[1]) : 4'b0000;
      applyStimulus(1'b0, 4'b1111, rl);
    end
    for (int c = 0; c < 8; c++) begin
      rl = m_granted[0] ? 4'(1 << m_owner[0]) : 4'b0000;
      rl = rl | (m_granted[1] ? 4'(1 << m_owner[1]) : 4'b0000);
      applyStimulus(1'b0, 4'b0000, rl);
    end

    // Stray releases from non-owners, then release with coincident self-request
    applyStimulus(1'b0, 4'b0010, 4'b0000);
    applyStimulus(1'b0, 4'b0000, 4'b0101);
    applyStimulus(1'b0, 4'b0000, 4'b0001);
    applyStimulus(1'b0, 4'b0010, 4'b0010);
    applyStimulus(1'b0, 4'b0000, 4'b0000);
    applyStimulus(1'b0, 4'b0000, 4'b0000);
    applyStimulus(1'b0, 4'b0000, 4'b0010);
    applyStimulus(1'b0, 4'b0000, 4'b0000);

    // Reset while requester 2 owns and 0/3 are pending
    applyStimulus(1'b0, 4'b0100, 4'b0000);
    applyStimulus(1'b0, 4'b1001, 4'b0000);
    applyStimulus(1'b1, 4'b0000, 4'b0000);
    repeat (3) applyStimulus(1'b0, 4'b0000, 4'b0000);

    // Long hold with a queued requester: forced revoke if enabled, otherwise held
    applyStimulus(1'b0, 4'b0001, 4'b0000);
    applyStimulus(1'b0, 4'b0010, 4'b0000);
    repeat (40) applyStimulus(1'b0, 4'b0000, 4'b0000);
    applyStimulus(1'b0, 4'b0000, 4'b0011);
    applyStimulus(1'b0, 4'b0000, 4'b0000);
    applyStimulus(1'b0, 4'b0000, 4'b0011);

    // Randomized traffic with owner-directed releases and occasional reset
    for (int c = 0; c < 1500; c++) begin
      rq  = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
      d   = $urandom_range(0, 1);
      sel = $urandom_range(0, 9);
      if (sel < 4 && m_granted[d]) rl = 4'(1 << m_owner[d]);
      else if (sel < 6) rl = 4'($urandom_range(0, 15));
      else rl = 4'b0000;
      applyStimulus($urandom_range(0, 99) == 0, rq, rl);
    end
    applyStimulus(1'b0, 4'b0000, 4'b0000);

    for (int w = 0; w < 4 && (q_exp[0].size() > 0 || q_exp[1].size() > 0); w++) begin
      @(negedge clk);
      #1;
    end
    if (q_exp[0].size() > 0 || q_exp[1].size() > 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain actual=%0d required=0", q_exp[0].size() + q_exp[1].size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
